// File: rtl/dual_port_bram_arbiter.sv
// Round-robin arbiter sharing one single-port BRAM (1-cycle read latency) between two
// burst requesters; a granted burst runs to completion before the next arbitration.
module dual_port_bram_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int MEM_SIZE   = 1024,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  // requester 0
  input  logic                  i_req0,
  input  logic                  i_mode0,
  input  logic [ADDR_WIDTH-1:0] i_addr0,
  input  logic [LEN_WIDTH-1:0]  i_len0,
  input  logic [DATA_WIDTH-1:0] i_wdata0,
  output logic                  o_gnt0,
  output logic                  o_wready0,
  output logic                  o_rvalid0,
  output logic                  o_done0,
  // requester 1
  input  logic                  i_req1,
  input  logic                  i_mode1,
  input  logic [ADDR_WIDTH-1:0] i_addr1,
  input  logic [LEN_WIDTH-1:0]  i_len1,
  input  logic [DATA_WIDTH-1:0] i_wdata1,
  output logic                  o_gnt1,
  output logic                  o_wready1,
  output logic                  o_rvalid1,
  output logic                  o_done1,
  // shared
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_busy,
  output logic [2:0]            o_dbg_state,
  // BRAM macro
  output logic [ADDR_WIDTH-1:0] bramAddr,
  output logic                  bramCe,
  output logic                  bramWe,
  output logic [DATA_WIDTH-1:0] bramWriteData,
  input  logic [DATA_WIDTH-1:0] bramReadData
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [ADDR_WIDTH:0] MEM_LIM = (ADDR_WIDTH+1)'(MEM_SIZE);

  state_t                 state_q, state_d;
  logic                   owner_q, owner_d;
  logic                   last_gnt_q, last_gnt_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d;
  logic [LEN_WIDTH-1:0]   beat_q, beat_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic                   ce_q, ce_d;
  logic                   we_q, we_d;
  logic                   busy_q, busy_d;
  logic [1:0]             gnt_q, gnt_d;
  logic [1:0]             wready_q, wready_d;
  logic [1:0]             rvalid_q, rvalid_d;
  logic [1:0]             done_q, done_d;

  logic                   req_any;
  logic                   win;
  logic                   sel_mode;
  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic [LEN_WIDTH-1:0]   sel_len;
  logic [ADDR_WIDTH:0]    addr_sum;
  logic [ADDR_WIDTH:0]    addr_wrap;
  logic [ADDR_WIDTH-1:0]  addr_inc;
  logic                   last_beat;

  // Handshake: a requester holds i_req{n} with a stable command until the one-cycle
  // o_gnt{n} pulse; dropping i_req{n} earlier withdraws the command. Write data is
  // taken in every cycle o_wready{n}=1, and read data on o_rdata is valid whenever
  // o_rvalid{n}=1. Neither side can stall a burst once it has been granted.
  always_comb begin
    req_any = i_req0 | i_req1;
    if (i_req0 && i_req1) begin
      win = ~last_gnt_q;
    end else begin
      win = i_req1;
    end
    sel_mode = win ? i_mode1 : i_mode0;
    sel_addr = win ? i_addr1 : i_addr0;
    sel_len  = win ? i_len1  : i_len0;
  end

  // Increment is done one bit wider so the modulo wrap never truncates a carry.
  always_comb begin
    addr_sum  = {1'b0, addr_q} + (ADDR_WIDTH+1)'(1);
    addr_wrap = (addr_sum >= MEM_LIM) ? (addr_sum - MEM_LIM) : addr_sum;
    addr_inc  = addr_wrap[ADDR_WIDTH-1:0];
    last_beat = (({1'b0, beat_q} + (LEN_WIDTH+1)'(1)) == {1'b0, len_q});
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_gnt_d = last_gnt_q;
    len_d      = len_q;
    beat_d     = beat_q;
    addr_d     = addr_q;
    ce_d       = 1'b0;
    we_d       = 1'b0;
    gnt_d      = 2'b00;
    wready_d   = 2'b00;
    rvalid_d   = 2'b00;
    done_d     = 2'b00;

    case (state_q)
      S_IDLE: begin
        if (req_any) begin
          owner_d    = win;
          last_gnt_d = win;
          len_d      = sel_len;
          beat_d     = '0;
          addr_d     = sel_addr;
          gnt_d[win] = 1'b1;
          if (sel_len == '0) begin
            // Empty burst: grant and completion share the same cycle.
            state_d     = S_DONE;
            done_d[win] = 1'b1;
          end else if (sel_mode) begin
            state_d       = S_WRITE;
            ce_d          = 1'b1;
            we_d          = 1'b1;
            wready_d[win] = 1'b1;
          end else begin
            state_d = S_READ;
            ce_d    = 1'b1;
          end
        end
      end

      S_WRITE: begin
        if (last_beat) begin
          state_d         = S_DONE;
          done_d[owner_q] = 1'b1;
        end else begin
          beat_d            = beat_q + LEN_WIDTH'(1);
          addr_d            = addr_inc;
          ce_d              = 1'b1;
          we_d              = 1'b1;
          wready_d[owner_q] = 1'b1;
        end
      end

      S_READ: begin
        // The address issued this cycle returns data next cycle.
        rvalid_d[owner_q] = 1'b1;
        if (last_beat) begin
          state_d = S_DRAIN;
        end else begin
          beat_d = beat_q + LEN_WIDTH'(1);
          addr_d = addr_inc;
          ce_d   = 1'b1;
        end
      end

      S_DRAIN: begin
        state_d         = S_DONE;
        done_d[owner_q] = 1'b1;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      owner_q    <= 1'b0;
      last_gnt_q <= 1'b1;
      len_q      <= '0;
      beat_q     <= '0;
      addr_q     <= '0;
      ce_q       <= 1'b0;
      we_q       <= 1'b0;
      busy_q     <= 1'b0;
      gnt_q      <= 2'b00;
      wready_q   <= 2'b00;
      rvalid_q   <= 2'b00;
      done_q     <= 2'b00;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_gnt_q <= last_gnt_d;
      len_q      <= len_d;
      beat_q     <= beat_d;
      addr_q     <= addr_d;
      ce_q       <= ce_d;
      we_q       <= we_d;
      busy_q     <= busy_d;
      gnt_q      <= gnt_d;
      wready_q   <= wready_d;
      rvalid_q   <= rvalid_d;
      done_q     <= done_d;
    end
  end

  assign o_gnt0      = gnt_q[0];
  assign o_gnt1      = gnt_q[1];
  assign o_wready0   = wready_q[0];
  assign o_wready1   = wready_q[1];
  assign o_rvalid0   = rvalid_q[0];
  assign o_rvalid1   = rvalid_q[1];
  assign o_done0     = done_q[0];
  assign o_done1     = done_q[1];
  assign o_busy      = busy_q;
  assign o_dbg_state = state_q;

  assign bramAddr      = addr_q;
  assign bramCe        = ce_q;
  assign bramWe        = we_q;
  // Write data is forced to zero outside write beats so nothing leaks from the idle port.
  assign bramWriteData = we_q ? (owner_q ? i_wdata1 : i_wdata0) : '0;
  assign o_rdata       = bramReadData;

endmodule

// File: tb/tb_dual_port_bram_arbiter.sv
// Self-checking bench for dual_port_bram_arbiter: directed scenarios plus random bursts,
// checked cycle by cycle against a burst-level timing model and a reference memory.
module tb_dual_port_bram_arbiter;

  localparam int DW  = 32;
  localparam int AW  = 10;
  localparam int LW  = 8;
  localparam int MEM = 1024;

  logic          clk = 1'b0;
  logic          reset;
  logic          mem_clr;
  logic          req   [2];
  logic          mode  [2];
  logic [AW-1:0] addr  [2];
  logic [LW-1:0] len   [2];
  logic [DW-1:0] wdata [2];

  logic          o_gnt0, o_wready0, o_rvalid0, o_done0;
  logic          o_gnt1, o_wready1, o_rvalid1, o_done1;
  logic [DW-1:0] o_rdata;
  logic          o_busy;
  logic [2:0]    dbg_state;
  logic [AW-1:0] bramAddr;
  logic          bramCe, bramWe;
  logic [DW-1:0] bramWriteData, bramReadData;

  logic [DW-1:0] bram    [MEM];
  logic [DW-1:0] ref_mem [MEM];

  int n_checks = 0;
  int n_fail   = 0;
  int exp_last = 1;

  always #5 clk = ~clk;

  dual_port_bram_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_SIZE(MEM), .LEN_WIDTH(LW)
  ) dut (
    .clk(clk), .reset(reset),
    .i_req0(req[0]), .i_mode0(mode[0]), .i_addr0(addr[0]), .i_len0(len[0]), .i_wdata0(wdata[0]),
    .o_gnt0(o_gnt0), .o_wready0(o_wready0), .o_rvalid0(o_rvalid0), .o_done0(o_done0),
    .i_req1(req[1]), .i_mode1(mode[1]), .i_addr1(addr[1]), .i_len1(len[1]), .i_wdata1(wdata[1]),
    .o_gnt1(o_gnt1), .o_wready1(o_wready1), .o_rvalid1(o_rvalid1), .o_done1(o_done1),
    .o_rdata(o_rdata), .o_busy(o_busy), .o_dbg_state(dbg_state),
    .bramAddr(bramAddr), .bramCe(bramCe), .bramWe(bramWe),
    .bramWriteData(bramWriteData), .bramReadData(bramReadData)
  );

  // BRAM macro stand-in: synchronous write, registered read.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < MEM; i++) bram[i] <= '0;
      bramReadData <= '0;
    end else if (bramCe) begin
      if (bramWe) bram[bramAddr] <= bramWriteData;
      else        bramReadData <= bram[bramAddr];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] ctl_obs();
    return {o_gnt0, o_gnt1, o_wready0, o_wready1, o_rvalid0, o_rvalid1,
            o_done0, o_done1, o_busy, bramCe, bramWe};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called in an idle cycle with requests already driven; plays one whole burst.
  task automatic run_arb(input bit hold, input bit poke, input bit fixed, input logic [DW-1:0] dbase);
    int w, o, a, l, total;
    bit m;
    logic [DW-1:0] wd;
    logic [1:0] eg, ew, er, ed;
    logic ece, ewe;
    w = (req[0] && req[1]) ? ((exp_last == 0) ? 1 : 0) : (req[1] ? 1 : 0);
    o = 1 - w;
    exp_last = w;
    m = mode[w];
    a = int'(addr[w]);
    l = int'(len[w]);
    total = (l == 0) ? 1 : (m ? l + 1 : l + 2);
    for (int c = 1; c <= total; c++) begin
      step();
      if (c == 1 && !hold) req[w] = 1'b0;
      if (poke && !hold && total >= 3) begin
        if (c == 2) req[o] = 1'b1;
        if (c == 3) req[o] = 1'b0;
      end
      wd = fixed ? (dbase + DW'(c - 1)) : DW'($urandom);
      wdata[w] = wd;
      wdata[o] = DW'($urandom);
      #1;
      eg = 2'b00; ew = 2'b00; er = 2'b00; ed = 2'b00; ece = 1'b0; ewe = 1'b0;
      if (c == 1) eg[w] = 1'b1;
      if (m && c <= l) begin ew[w] = 1'b1; ece = 1'b1; ewe = 1'b1; end
      if (!m && c <= l) ece = 1'b1;
      if (!m && c >= 2 && c <= l + 1) er[w] = 1'b1;
      if (c == total) ed[w] = 1'b1;
      chk($sformatf("ctl p%0d c%0d", w, c), 64'(ctl_obs()),
          64'({eg[0], eg[1], ew[0], ew[1], er[0], er[1], ed[0], ed[1], 1'b1, ece, ewe}));
      if (c <= l) chk($sformatf("bram_addr c%0d", c), 64'(bramAddr), 64'((a + c - 1) % MEM));
      if (m && c <= l) begin
        chk($sformatf("bram_wdata c%0d", c), 64'(bramWriteData), 64'(wd));
        ref_mem[(a + c - 1) % MEM] = wd;
      end
      if (!m && c >= 2 && c <= l + 1)
        chk($sformatf("rdata c%0d", c), 64'(o_rdata), 64'(ref_mem[(a + c - 2) % MEM]));
    end
    step();
    chk("idle after burst", 64'(ctl_obs()), 64'(0));
  endtask

  task automatic set_cmd(input int p, input bit m, input int a, input int l);
    mode[p] = m;
    addr[p] = AW'(a);
    len[p]  = LW'(l);
  endtask

  initial begin
    int pat;
    reset = 1'b1;
    mem_clr = 1'b1;
    for (int p = 0; p < 2; p++) begin
      req[p] = 1'b0; mode[p] = 1'b0; addr[p] = '0; len[p] = '0; wdata[p] = '0;
    end
    for (int i = 0; i < MEM; i++) ref_mem[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    mem_clr = 1'b0;
    chk("reset ctl", 64'(ctl_obs()), 64'(0));
    chk("reset addr", 64'(bramAddr), 64'(0));
    chk("reset wdata", 64'(bramWriteData), 64'(0));
    chk("reset state", 64'(dbg_state), 64'(0));
    reset = 1'b0;
    step();

    // P0 write 0x010 len 4 with A0..A3, then P1 reads it back.
    set_cmd(0, 1'b1, 'h010, 4); req[0] = 1'b1;
    run_arb(1'b0, 1'b0, 1'b1, 32'hA0);
    set_cmd(1, 1'b0, 'h010, 4); req[1] = 1'b1;
    run_arb(1'b0, 1'b0, 1'b0, '0);

    // Continuous contention, len 2: grants alternate starting with P0.
    set_cmd(0, 1'b1, 'h040, 2);
    set_cmd(1, 1'b0, 'h010, 2);
    req[0] = 1'b1; req[1] = 1'b1;
    for (int i = 0; i < 4; i++) run_arb(1'b1, 1'b0, 1'b0, '0);
    req[0] = 1'b0; req[1] = 1'b0;

    // Wrap at the top of memory, then read back through the wrap.
    set_cmd(0, 1'b1, 1022, 4); req[0] = 1'b1;
    run_arb(1'b0, 1'b0, 1'b0, '0);
    set_cmd(1, 1'b0, 1022, 4); req[1] = 1'b1;
    run_arb(1'b0, 1'b0, 1'b0, '0);

    // Empty burst.
    set_cmd(1, 1'b1, 'h200, 0); req[1] = 1'b1;
    run_arb(1'b0, 1'b0, 1'b0, '0);

    // Random bursts, some with a request withdrawn while the other port is busy.
    for (int i = 0; i < 24; i++) begin
      pat = $urandom_range(0, 2);
      for (int p = 0; p < 2; p++) begin
        set_cmd(p, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0) ? $urandom_range(1016, 1023) : $urandom_range(0, 1023),
                $urandom_range(0, 12));
      end
      req[0] = (pat != 1);
      req[1] = (pat != 0);
      run_arb(1'b0, (pat != 2) && ($urandom_range(0, 1) == 1), 1'b0, '0);
      req[0] = 1'b0; req[1] = 1'b0;
    end

    // Reset in cycle 2 of a len-8 P1 read abandons the burst.
    set_cmd(1, 1'b0, 'h100, 8); req[1] = 1'b1; req[0] = 1'b0;
    step();
    req[1] = 1'b0;
    #1;
    chk("rst c1 ctl", 64'(ctl_obs()), 64'(11'b010_0000_0110));
    step();
    #1;
    chk("rst c2 ctl", 64'(ctl_obs()), 64'(11'b000_0010_0110));
    #2 reset = 1'b1;
    #1;
    chk("async reset ctl", 64'(ctl_obs()), 64'(0));
    chk("async reset addr", 64'(bramAddr), 64'(0));
    chk("async reset wdata", 64'(bramWriteData), 64'(0));
    chk("async reset state", 64'(dbg_state), 64'(0));
    #1 reset = 1'b0;
    exp_last = 1;
    for (int i = 0; i < 12; i++) begin
      step();
      chk($sformatf("no done after reset %0d", i), 64'(ctl_obs()), 64'(0));
    end
    set_cmd(0, 1'b0, 'h010, 2);
    set_cmd(1, 1'b1, 'h300, 3);
    req[0] = 1'b1; req[1] = 1'b1;
    run_arb(1'b0, 1'b0, 1'b0, '0);
    req[0] = 1'b0; req[1] = 1'b0;
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
